// File: rtl/stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew interlock against the E and M writers plus the MDU busy counter.
// Optional STALL_STAT_EN adds free-running stall statistics counters.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
`ifdef STALL_STAT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        md_busy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0] cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       stall;

  // A producer stalls D only while its result arrives later than D needs it.
  always_comb begin
    stall_rs = (D_rs_addr != 5'd0) &&
               (((E_wa == D_rs_addr) && (E_tnew > D_tuse_rs)) ||
                ((M_wa == D_rs_addr) && (M_tnew > D_tuse_rs)));
    stall_rt = (D_rt_addr != 5'd0) &&
               (((E_wa == D_rt_addr) && (E_tnew > D_tuse_rt)) ||
                ((M_wa == D_rt_addr) && (M_tnew > D_tuse_rt)));
    md_busy  = (cnt != 4'd0);
    stall_md = D_is_md && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
    F_en     = ~stall;
    D_en     = ~stall;
    E_flush  = stall;
  end

  // A start in E always reloads, even if a previous operation is still counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (E_md_start) begin
      cnt <= E_md_div ? DIV_LD : MULT_LD;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef STALL_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall)    stall_cnt    <= stall_cnt + 32'd1;
      if (stall_md) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: the driver queues hand-computed outputs per cycle, the monitor checks them.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  D_rs_addr = '0, D_rt_addr = '0, E_wa = '0, M_wa = '0;
  logic [1:0]  D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, E_tnew = '0, M_tnew = '0;
  logic        D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
  logic        F_en, D_en, E_flush, md_busy;
`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
`ifdef STALL_STAT_EN
    .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .F_en(F_en), .D_en(D_en), .E_flush(E_flush), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] exp;   // {F_en, D_en, E_flush, md_busy}
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_now;

  // Monitor: outputs are settled mid-cycle, so expectations are popped on the falling edge
  // (or immediately, for the asynchronous reset checks).
  initial begin
    forever begin
      @(negedge clk or sample_now);
      if (q.size() != 0) begin
        exp_t e;
        logic [3:0] got;
        e   = q.pop_front();
        got = {F_en, D_en, E_flush, md_busy};
        n_cmp++;
        if (got !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got F_en/D_en/E_flush/md_busy=%b required %b", e.name, got, e.exp);
        end
      end
    end
  end

  function automatic logic [3:0] pack_exp(input logic s, input logic b);
    return {~s, ~s, s, b};
  endfunction

  task automatic drive(input string nm,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic md,
                       input logic [4:0] ewa, input logic [1:0] etn,
                       input logic [4:0] mwa, input logic [1:0] mtn,
                       input logic st, input logic dv,
                       input logic es, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    D_rs_addr = rs; D_tuse_rs = tur; D_rt_addr = rt; D_tuse_rt = tut;
    D_is_md = md; E_wa = ewa; E_tnew = etn; M_wa = mwa; M_tnew = mtn;
    E_md_start = st; E_md_div = dv;
    e.name = nm;
    e.exp  = pack_exp(es, eb);
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic md, input logic es, input logic eb);
    drive(nm, 5'd0, 2'd3, 5'd0, 2'd3, md, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, es, eb);
  endtask

  task automatic check_now(input string nm, input logic es, input logic eb);
    exp_t e;
    e.name = nm;
    e.exp  = pack_exp(es, eb);
    q.push_back(e);
    ->sample_now;
    #0;
  endtask

  initial begin
    // Reset state while reset is held.
    #2 check_now("reset_state", 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // Load-use: lw in E feeding rs, then still unready in M for a tuse-0 consumer.
    drive("lu_e",   5'd5, 2'd1, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("lu_m",   5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("lu_clr", 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // mult in E at t with a dependent mfhi held in D: stall t..t+5, busy t+1..t+5.
    drive("mult_t0", 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) idle($sformatf("mult_t%0d", i), 1'b1, 1'b1, 1'b1);
    idle("mult_t6", 1'b1, 1'b0, 1'b0);

`ifdef STALL_STAT_EN
    n_cmp++;
    if (stall_cnt !== 32'd8) begin
      n_bad++;
      $display("FAIL stat_stall_cnt: got %0d required 8", stall_cnt);
    end
    n_cmp++;
    if (md_stall_cnt !== 32'd6) begin
      n_bad++;
      $display("FAIL stat_md_stall_cnt: got %0d required 6", md_stall_cnt);
    end
`endif

    // Register 0 and forwardable cases.
    drive("r0",       5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("fwd_rt",   5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("m_equal",  5'd6, 2'd1, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("tuse3",    5'd6, 2'd3, 5'd0, 2'd3, 1'b0, 5'd6, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("rt_e",     5'd0, 2'd3, 5'd7, 2'd0, 1'b0, 5'd7, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("rt_m",     5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("rs_wrong", 5'd4, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // div with no MD instruction in D: busy exactly 10 cycles, never a stall.
    drive("div_t0", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) idle($sformatf("div_t%0d", i), 1'b0, 1'b0, 1'b1);
    idle("div_t11", 1'b0, 1'b0, 1'b0);

    // Restart while busy: div, then a mult start one cycle later reloads 5.
    drive("rl_t0", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive("rl_t1", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i <= 6; i++) idle($sformatf("rl_t%0d", i), 1'b0, 1'b0, 1'b1);
    idle("rl_t7", 1'b0, 1'b0, 1'b0);

    // Data and MD stall together, then an MD instruction in D with an idle MDU.
    drive("both_t0", 5'd2, 2'd0, 5'd0, 2'd3, 1'b1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("both_t1", 5'd2, 2'd0, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 2; i <= 5; i++) idle($sformatf("both_t%0d", i), 1'b1, 1'b1, 1'b1);
    idle("md_idle", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset three cycles into a div, with an MD instruction waiting in D.
    drive("ar_t0", 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("ar_t1", 1'b0, 1'b0, 1'b1);
    idle("ar_t2", 1'b0, 1'b0, 1'b1);
    idle("ar_t3", 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_now("ar_async", 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    idle("ar_after1", 1'b1, 1'b0, 1'b0);
    idle("ar_after2", 1'b1, 1'b0, 1'b0);
    idle("ar_after3", 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
